// File: rtl/booth_mul_ctrl.sv
// booth_mul_ctrl: iterative radix-4 Booth multiplier for the RV64M multiply path.
// One Booth digit (partial product) is accumulated per cycle; 33 digits cover the
// 66-bit extended multiplier. Optional build macro MUL_FAST_WORD_EN: when defined,
// mulw stops after 17 digits because its 34-bit sign-extended multiplier is exhausted.
module booth_mul_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mul_valid,
    output logic        mul_ready,
    input  logic [2:0]  mul_op,
    input  logic [63:0] mul_a,
    input  logic [63:0] mul_b,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_result,
    output logic        busy
);

    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_MULW   = 3'b100;
    localparam logic [5:0] ITER_FULL = 6'd33;
`ifdef MUL_FAST_WORD_EN
    localparam logic [5:0] ITER_WORD = 6'd17;
`endif

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t              state_q, state_d;
    logic                out_valid_q, busy_q;
    logic [63:0]         out_result_q;

    logic signed [131:0] a_sh_q;     // sign-extended multiplicand, pre-shifted by 2i
    logic [66:0]         b_sh_q;     // {multiplier, B[-1]}, consumed two bits per cycle
    logic signed [131:0] acc_q;
    logic [5:0]          cnt_q;
    logic [5:0]          n_q;
    logic [2:0]          op_q;

    logic signed [65:0]  a_ext, b_ext;
    logic signed [131:0] pp, acc_sum;
    logic [5:0]          n_sel;
    logic                accept, last, load_result;
    logic [63:0]         result_d;

    // Pick the product slice the op returns; unknown ops behave as mul.
    function automatic logic [63:0] select_result(input logic [2:0] op, input logic [127:0] p);
        case (op)
            OP_MULH, OP_MULHSU, OP_MULHU: return p[127:64];
            OP_MULW:                      return {{32{p[31]}}, p[31:0]};
            default:                      return p[63:0];
        endcase
    endfunction

    assign mul_ready   = (state_q == S_IDLE) & ~flush;
    assign accept      = mul_valid & mul_ready;
    assign last        = (cnt_q == (n_q - 6'd1));
    assign load_result = (state_q == S_BUSY) & last & ~flush;
    assign out_valid   = out_valid_q;
    assign busy        = busy_q;
    assign out_result  = out_result_q;

`ifdef MUL_FAST_WORD_EN
    assign n_sel = (mul_op == OP_MULW) ? ITER_WORD : ITER_FULL;
`else
    assign n_sel = ITER_FULL;
`endif

    // Extend both operands to 66 bits according to the signedness of the op.
    always_comb begin
        a_ext = {{2{mul_a[63]}}, mul_a};
        b_ext = {{2{mul_b[63]}}, mul_b};
        case (mul_op)
            OP_MULHSU: b_ext = {2'b00, mul_b};
            OP_MULHU: begin
                a_ext = {2'b00, mul_a};
                b_ext = {2'b00, mul_b};
            end
            OP_MULW: begin
                a_ext = {{34{mul_a[31]}}, mul_a[31:0]};
                b_ext = {{34{mul_b[31]}}, mul_b[31:0]};
            end
            default: ;
        endcase
    end

    // Decode the current Booth triplet into a signed partial product and add it.
    always_comb begin
        case (b_sh_q[2:0])
            3'b001, 3'b010: pp = a_sh_q;
            3'b011:         pp = a_sh_q <<< 1;
            3'b100:         pp = -(a_sh_q <<< 1);
            3'b101, 3'b110: pp = -a_sh_q;
            default:        pp = '0;
        endcase
        acc_sum  = acc_q + pp;
        result_d = select_result(op_q, acc_sum[127:0]);
    end

    // Next-state logic; flush overrides every other transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (mul_valid) state_d = S_BUSY;
            S_BUSY: if (last)      state_d = S_DONE;
            S_DONE: if (out_ready) state_d = S_IDLE;
            default:               state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    // Control state and registered outputs, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            out_result_q <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= (state_d == S_DONE);
            busy_q      <= (state_d != S_IDLE);
            if (load_result) out_result_q <= result_d;
        end
    end

    // Iteration datapath: load on accept, then shift operands and accumulate each BUSY cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_sh_q <= {{66{a_ext[65]}}, a_ext};
            b_sh_q <= {b_ext, 1'b0};
            acc_q  <= '0;
            cnt_q  <= '0;
            n_q    <= n_sel;
            op_q   <= mul_op;
        end else if (state_q == S_BUSY) begin
            a_sh_q <= a_sh_q <<< 2;
            b_sh_q <= {{2{b_sh_q[66]}}, b_sh_q[66:2]};
            acc_q  <= acc_sum;
            cnt_q  <= cnt_q + 6'd1;
        end
    end

endmodule
